// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch push side, decode pop side, flush and status.
// The master modport is the fetch/decode environment; the slave modport is the queue.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32,
  parameter int unsigned PCW   = 25
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic           in_valid;
  logic [IW-1:0]  in_inst;
  logic [PCW-1:0] in_pc;
  logic           in_ready;
  logic           flush;
  logic           out_valid;
  logic [IW-1:0]  out_inst;
  logic [PCW-1:0] out_pc;
  logic           out_ready;
  logic [CW-1:0]  count;
  logic           overflow;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, count, overflow
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_inst, out_pc, count, overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with credit-style in_ready and flush squash.
// Optional same-cycle bypass of an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32,
  parameter int unsigned PCW   = 25
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IW-1:0]  inst;
    logic [PCW-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          shadow;

  entry_t head_c;
  logic   out_valid_c;
  logic   bypass_hit_c;
  logic   pop_c;
  logic   push_c;
  logic   full_c;
  logic   wr_en_c;
  logic   rd_adv_c;

  // Head selection; an empty queue may forward the incoming word when bypass is built in.
  always_comb begin
    head_c       = mem[rp];
    bypass_hit_c = 1'b0;
    out_valid_c  = (count_q != '0) && !bus.flush && !shadow;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_hit_c = (count_q == '0) && !shadow && !bus.flush && bus.in_valid;
    if (bypass_hit_c) begin
      out_valid_c = 1'b1;
      head_c      = '{inst: bus.in_inst, pc: bus.in_pc};
    end
`endif
  end

  assign pop_c    = out_valid_c && bus.out_ready;
  assign push_c   = bus.in_valid && !shadow && !bus.flush;
  assign full_c   = (count_q == CW'(DEPTH));
  // A bypassed word consumed this cycle never touches storage.
  assign wr_en_c  = push_c && !(bypass_hit_c && bus.out_ready) && (!full_c || pop_c);
  assign rd_adv_c = pop_c && !bypass_hit_c;

  // One slot stays reserved for the RAM read fetch issued last cycle.
  assign bus.in_ready  = (count_q <= (CW'(DEPTH - 2) + CW'(pop_c)));
  assign bus.out_valid = out_valid_c;
  assign bus.out_inst  = head_c.inst;
  assign bus.out_pc    = head_c.pc;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rp         <= '0;
      wp         <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shadow     <= 1'b0;
    end else begin
      // Each flush re-arms the squash of the word already in flight.
      shadow <= bus.flush;
      if (bus.flush) begin
        rp      <= '0;
        wp      <= '0;
        count_q <= '0;
      end else begin
        if (wr_en_c)  wp <= wp + AW'(1);
        if (rd_adv_c) rp <= rp + AW'(1);
        count_q <= count_q + CW'(wr_en_c) - CW'(rd_adv_c);
        if (push_c && full_c && !pop_c) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en_c) mem[wp] <= '{inst: bus.in_inst, pc: bus.in_pc};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 32;
  localparam int unsigned PCW   = 25;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH), .IW(IW), .PCW(PCW)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .IW(IW), .PCW(PCW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  inst;
  } word_t;

  word_t          mq[$];
  bit             m_ovf;
  bit             m_shadow;
  logic [PCW-1:0] got[$];
  int             errors = 0;
  int             checks = 0;
  bit             rdy_d;

  // One clock of stimulus: drive, compare against the model, then advance the model.
  task automatic step(input bit r, input bit fl, input bit iv, input logic [PCW-1:0] pc,
                      input bit ordy, output bit rdy);
    word_t         w;
    word_t         h;
    bit            ev;
    bit            do_pop;
    bit            was_empty;
    bit            ir;
    bit            drop;
    int            occ;
    logic [CW-1:0] ec;
    w.pc   = pc;
    w.inst = $urandom;
    @(negedge clk);
    rst           = r;
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_inst   = w.inst;
    bus.out_ready = ordy;
    #1;
    was_empty = (mq.size() == 0);
    ev        = !fl && !m_shadow && (!was_empty || (BYP && iv));
    h         = was_empty ? w : mq[0];
    do_pop    = ev && ordy;
    occ       = mq.size() - (do_pop ? 1 : 0);
    ir        = (occ <= int'(DEPTH) - 2);
    ec        = CW'(mq.size());
    checks++;
    if (bus.out_valid !== ev) begin
      errors++; $display("FAIL out_valid: got %b want %b", bus.out_valid, ev);
    end
    if (ev) begin
      checks++;
      if (bus.out_pc !== h.pc) begin
        errors++; $display("FAIL out_pc: got %0h want %0h", bus.out_pc, h.pc);
      end
      checks++;
      if (bus.out_inst !== h.inst) begin
        errors++; $display("FAIL out_inst: got %0h want %0h", bus.out_inst, h.inst);
      end
    end
    checks++;
    if (bus.in_ready !== ir) begin
      errors++; $display("FAIL in_ready: got %b want %b", bus.in_ready, ir);
    end
    checks++;
    if (bus.count !== ec) begin
      errors++; $display("FAIL count: got %0d want %0d", bus.count, ec);
    end
    checks++;
    if (bus.overflow !== m_ovf) begin
      errors++; $display("FAIL overflow: got %b want %b", bus.overflow, m_ovf);
    end
    if (bus.out_valid === 1'b1 && ordy) got.push_back(bus.out_pc);
    rdy = ir;
    if (r) begin
      mq.delete(); m_ovf = 0; m_shadow = 0;
    end else if (fl) begin
      mq.delete(); m_shadow = 1;
    end else begin
      drop     = m_shadow;
      m_shadow = 0;
      if (do_pop && !was_empty) void'(mq.pop_front());
      if (iv && !drop && !(was_empty && do_pop)) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 0, '0, ordy, rdy_d);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) idle(1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0, rdy_d);
    step(1, 0, 0, '0, 0, rdy_d);
  endtask

  task automatic test_reset();
    do_reset();
    idle(0);
    checks++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d ov=%b ir=%b of=%b want 0 0 1 0",
               bus.count, bus.out_valid, bus.in_ready, bus.overflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, PCW'(i), 0, rdy_d);
      checks++;
      if (bus.in_ready !== (i < 3)) begin
        errors++; $display("FAIL fill_in_ready[%0d]: got %b want %b", i, bus.in_ready, (i < 3));
      end
    end
    idle(0);
    checks++;
    if (bus.count !== CW'(4) || bus.out_pc !== PCW'(0) || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got cnt=%0d pc=%0h of=%b want 4 0 0", bus.count, bus.out_pc, bus.overflow);
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 1, PCW'(4), 0, rdy_d);
    idle(0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== CW'(4)) begin
      errors++; $display("FAIL overflow_set: got of=%b cnt=%0d want 1 4", bus.overflow, bus.count);
    end
    idle(0);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: got %b want 1", bus.overflow);
    end
    got.delete();
    drain();
    checks++;
    if (got.size() != 4 || got[0] !== PCW'(0) || got[1] !== PCW'(1) || got[2] !== PCW'(2) || got[3] !== PCW'(3)) begin
      errors++; $display("FAIL overflow_drain: got %0d words want pcs 0,1,2,3", got.size());
    end
  endtask

  task automatic test_concurrent_full();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, PCW'(i), 0, rdy_d);
    got.delete();
    step(0, 0, 1, PCW'(9), 1, rdy_d);
    idle(0);
    checks++;
    if (bus.count !== CW'(4) || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL conc_full: got cnt=%0d of=%b want 4 0", bus.count, bus.overflow);
    end
    drain();
    checks++;
    if (got.size() != 5 || got[0] !== PCW'(0) || got[4] !== PCW'(9)) begin
      errors++; $display("FAIL conc_order: got %0d words want 5 from pc 0 ending at pc 9", got.size());
    end
  endtask

  task automatic test_wrap();
    int             sent;
    bit             pend;
    bit             rdy;
    logic [PCW-1:0] ppc;
    bit             ok;
    sent = 0; pend = 0; ppc = '0;
    got.delete();
    for (int cyc = 0; cyc < 200 && got.size() < 10; cyc++) begin
      step(0, 0, pend, ppc, cyc[0], rdy);
      pend = rdy && (sent < 10);
      if (pend) begin
        ppc = PCW'(sent);
        sent++;
      end
    end
    ok = (got.size() == 10);
    for (int i = 0; i < 10 && ok; i++) if (got[i] !== PCW'(i)) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wrap_order: got %0d words (in order=%b) want pcs 0..9", got.size(), ok);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL wrap_overflow: got %b want 0", bus.overflow);
    end
    drain();
  endtask

  task automatic test_flush_shadow();
    step(0, 0, 1, PCW'(1), 0, rdy_d);
    step(0, 0, 1, PCW'(2), 0, rdy_d);
    step(0, 1, 1, PCW'(7), 0, rdy_d);
    step(0, 0, 1, PCW'(8), 0, rdy_d);
    checks++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty: got cnt=%0d ov=%b want 0 0", bus.count, bus.out_valid);
    end
    step(0, 0, 1, PCW'(32'h100), 0, rdy_d);
    got.delete();
    idle(1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== PCW'(32'h100)) begin
      errors++; $display("FAIL flush_next: got ov=%b pc=%0h want 1 100", bus.out_valid, bus.out_pc);
    end
    drain();
    checks++;
    if (got.size() != 1) begin
      errors++; $display("FAIL flush_drop: got %0d words want 1", got.size());
    end
  endtask

  task automatic test_latency();
    step(0, 0, 1, PCW'(32'h40), 1, rdy_d);
`ifdef FETCH_QUEUE_BYPASS_EN
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== PCW'(32'h40)) begin
      errors++; $display("FAIL bypass_same: got ov=%b pc=%0h want 1 40", bus.out_valid, bus.out_pc);
    end
    idle(1);
    checks++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bypass_after: got cnt=%0d ov=%b want 0 0", bus.count, bus.out_valid);
    end
`else
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_same: got ov=%b want 0", bus.out_valid);
    end
    idle(1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== PCW'(32'h40)) begin
      errors++; $display("FAIL latency_next: got ov=%b pc=%0h want 1 40", bus.out_valid, bus.out_pc);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, PCW'(3), 0, rdy_d);
    step(0, 0, 1, PCW'(4), 0, rdy_d);
    step(1, 1, 1, PCW'(32'h55), 1, rdy_d);
    idle(0);
    checks++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got cnt=%0d ov=%b of=%b want 0 0 0", bus.count, bus.out_valid, bus.overflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 60,
           PCW'(i), $urandom_range(0, 1) == 1, rdy_d);
    end
    drain();
  endtask

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_concurrent_full();
    test_wrap();
    test_flush_shadow();
    test_latency();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
